// File: rtl/mac_accum_seq.sv
// ============================================================================
// Module      : mac_accum_seq
// Description : Operand-side sequencer for the 32x32+64 mac datapath. Streams
//               operand pairs into the mac, keeps the running sum and returns
//               each finished dot-product over a valid/ready result port.
//               Optional saturation: define MAC_ACCUM_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_accum_seq #(
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_last,
  output logic [31:0]      mac_multiplicand,
  output logic [31:0]      mac_multiplier,
  output logic [63:0]      mac_acc_in,
  input  logic [64:0]      mac_acc_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic             res_ovf,
  output logic [CNT_W-1:0] res_count
);

  localparam logic [0:0] c_st_run  = 1'b0;
  localparam logic [0:0] c_st_hold = 1'b1;
  localparam int         c_cnt_w1  = CNT_W + 1;
  localparam logic [CNT_W:0] c_max_terms = c_cnt_w1'(MAX_TERMS);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic             r_s1;
  logic             r_s1_last;
  logic [CNT_W-1:0] r_term_cnt;
  logic [CNT_W:0]   w_pending_cnt;
  logic             w_accept;
  logic             w_close;
  logic             w_release;
  logic [63:0]      w_commit_sum;

  assign w_accept  = in_valid && in_ready;
  assign w_close   = r_s1 && r_s1_last;
  assign w_release = (r_state == c_st_hold) && res_valid && res_ready;

  // The staged term has not reached r_term_cnt yet, so it is counted here
  // to close back-to-back streams on exactly MAX_TERMS terms.
  assign w_pending_cnt = {1'b0, r_term_cnt} + c_cnt_w1'(r_s1) + c_cnt_w1'(1);

`ifdef MAC_ACCUM_SAT_EN
  assign w_commit_sum = mac_acc_out[64] ? 64'hFFFF_FFFF_FFFF_FFFF : mac_acc_out[63:0];
`else
  assign w_commit_sum = mac_acc_out[63:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_run: begin
        if (w_close) begin
          w_state_next = c_st_hold;
        end
      end
      c_st_hold: begin
        if (res_valid && res_ready) begin
          w_state_next = c_st_run;
        end
      end
      default: w_state_next = c_st_run;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    if (r_state == c_st_run) begin
      in_ready = !(r_s1 && r_s1_last);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_multiplicand <= '0;
      mac_multiplier   <= '0;
      mac_acc_in       <= '0;
      r_s1             <= 1'b0;
      r_s1_last        <= 1'b0;
      r_term_cnt       <= '0;
      res_valid        <= 1'b0;
      res_data         <= '0;
      res_ovf          <= 1'b0;
      res_count        <= '0;
    end else begin
      if (w_accept) begin
        mac_multiplicand <= in_a;
        mac_multiplier   <= in_b;
        r_s1             <= 1'b1;
        r_s1_last        <= in_last || (w_pending_cnt == c_max_terms);
      end else if (r_s1) begin
        r_s1 <= 1'b0;
      end

      if (r_s1) begin
        mac_acc_in <= w_commit_sum;
        res_ovf    <= res_ovf | mac_acc_out[64];
        r_term_cnt <= r_term_cnt + 1'b1;
        if (r_s1_last) begin
          res_data  <= w_commit_sum;
          res_count <= r_term_cnt + 1'b1;
          res_valid <= 1'b1;
        end
      end

      // Only reachable in HOLD, where no term is staged.
      if (w_release) begin
        res_valid  <= 1'b0;
        mac_acc_in <= '0;
        r_term_cnt <= '0;
        res_ovf    <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
